// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types for the sequential ALU.
//   alu_op_e    - operation codes carried on the 4-bit op port
//   alu_state_e - handshake FSM states (IDLE accepts, BUSY iterates, DONE presents)
//   alu_flags_t - registered status flags {c, z, n, v}
// Optional multiplier is controlled by the macro ALU_SEQ_MUL_EN (see alu_seq.sv).
package alu_seq_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOTA = 4'd5,
        OP_NOTB = 4'd6,
        OP_SHL  = 4'd7,
        OP_SHR  = 4'd8,
        OP_MUL  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    typedef struct packed {
        logic c;
        logic z;
        logic n;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: multicycle datapath used while the ALU is in BUSY.
//   Shifts move one bit per cycle; the multiplier (ALU_SEQ_MUL_EN only) runs a
//   right-shifting shift-add over a 2*WIDTH accumulator for WIDTH iterations.
// Ports:
//   clk, rst        clock, synchronous active-high reset (control state only)
//   start           load operands and begin iterating (count must be nonzero)
//   is_mul, is_shr  operation select latched at start (SHL when both low)
//   a, b            operands; shamt is the shift amount for shifts
//   done            high during the cycle whose clock edge performs the last step
//   res, carry      value the final step produces (valid while done is high)
module alu_iter_unit
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_mul,
    input  logic             is_shr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             carry
);

    localparam logic [SHW:0] CNT_ONE = {{SHW{1'b0}}, 1'b1};

    logic             busy;
    logic [SHW:0]     count;
    logic             mode_mul;
    logic             mode_shr;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_step;
    logic             shift_out;

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH:0]     part_sum;
`else
    logic unused_mul_sel;
    assign unused_mul_sel = is_mul;
`endif

    assign done = busy && (count == CNT_ONE);

    always_comb begin
        work_step = mode_shr ? (work >> 1) : (work << 1);
        shift_out = mode_shr ? work[0] : work[WIDTH-1];
    end

`ifdef ALU_SEQ_MUL_EN
    // Upper half accumulates the multiplicand when the current multiplier bit
    // (acc[0]) is set; the whole accumulator then shifts right, so after WIDTH
    // steps the upper/lower halves hold the high/low product.
    always_comb begin
        part_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_step = {part_sum, acc[WIDTH-1:1]};
        res      = mode_mul ? acc_step[WIDTH-1:0] : work_step;
        carry    = mode_mul ? (|acc_step[2*WIDTH-1:WIDTH]) : shift_out;
    end
`else
    always_comb begin
        res   = work_step;
        carry = shift_out;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            count    <= '0;
            mode_mul <= 1'b0;
            mode_shr <= 1'b0;
        end else if (start) begin
            busy     <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
            count    <= is_mul ? (SHW+1)'(WIDTH) : {1'b0, shamt};
            mode_mul <= is_mul;
`else
            count    <= {1'b0, shamt};
            mode_mul <= 1'b0;
`endif
            mode_shr <= is_shr;
        end else if (busy) begin
            count <= count - CNT_ONE;
            if (count == CNT_ONE) begin
                busy <= 1'b0;
            end
        end
    end

    // Operand registers carry no reset; they are always reloaded by start.
    always_ff @(posedge clk) begin
        if (start) begin
            work <= a;
        end else if (busy) begin
            work <= work_step;
        end
    end

`ifdef ALU_SEQ_MUL_EN
    always_ff @(posedge clk) begin
        if (start) begin
            acc   <= {{WIDTH{1'b0}}, b};
            mcand <= a;
        end else if (busy) begin
            acc <= acc_step;
        end
    end
`else
    logic unused_b;
    assign unused_b = ^b;
`endif

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU with registered result and status flags.
//   Single-cycle ops complete at the accept edge; nonzero shifts and (when the
//   macro ALU_SEQ_MUL_EN is defined) MUL iterate in alu_iter_unit while BUSY.
//   Without ALU_SEQ_MUL_EN op 9 behaves as the default pass-A op.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready only in IDLE)
//   a, b, op              operands and op code (b[SHW-1:0] = shift amount)
//   out_valid / out_ready result handshake (out_valid only in DONE)
//   result                registered result
//   flag_c/z/n/v          carry/borrow/shift-out/mul-high, zero, negative, overflow
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);

    alu_state_e       state;
    alu_state_e       state_next;
    alu_op_e          op_e;
    alu_flags_t       flags;

    logic             accept;
    logic             is_shift;
    logic             is_mul;
    logic             start_iter;
    logic [SHW-1:0]   shamt;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c;
    logic             sc_v;

    logic             iter_done;
    logic [WIDTH-1:0] iter_res;
    logic             iter_carry;

    function automatic alu_flags_t make_flags(input logic [WIDTH-1:0] r,
                                              input logic c, input logic v);
        alu_flags_t f;
        f.c = c;
        f.z = (r == '0);
        f.n = r[WIDTH-1];
        f.v = v;
        return f;
    endfunction

    assign op_e      = alu_op_e'(op);
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign shamt     = b[SHW-1:0];
    assign is_shift  = (op_e == OP_SHL) || (op_e == OP_SHR);
`ifdef ALU_SEQ_MUL_EN
    assign is_mul    = (op_e == OP_MUL);
`else
    assign is_mul    = 1'b0;
`endif
    // A zero-amount shift has nothing to iterate and completes like a logic op.
    assign start_iter = accept && (is_mul || (is_shift && (shamt != '0)));

    assign flag_c = flags.c;
    assign flag_z = flags.z;
    assign flag_n = flags.n;
    assign flag_v = flags.v;

    // Single-cycle datapath
    always_comb begin
        sum_ext  = {1'b0, a} + {1'b0, b};
        diff_ext = {1'b0, a} - {1'b0, b};
        sc_res   = a;
        sc_c     = 1'b0;
        sc_v     = 1'b0;
        case (op_e)
            OP_ADD: begin
                sc_res = sum_ext[WIDTH-1:0];
                sc_c   = sum_ext[WIDTH];
                sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = diff_ext[WIDTH-1:0];
                sc_c   = diff_ext[WIDTH];   // borrow out of the extended subtract
                sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_NOTA: sc_res = ~a;
            OP_NOTB: sc_res = ~b;
            default: sc_res = a;
        endcase
    end

    alu_iter_unit #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (start_iter),
        .is_mul (is_mul),
        .is_shr (op_e == OP_SHR),
        .a      (a),
        .b      (b),
        .shamt  (shamt),
        .done   (iter_done),
        .res    (iter_res),
        .carry  (iter_carry)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = start_iter ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (iter_done) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Result/flag register: loads only at completion, so it holds through DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            flags  <= '0;
        end else if (accept && !start_iter) begin
            result <= sc_res;
            flags  <= make_flags(sc_res, sc_c, sc_v);
        end else if ((state == ST_BUSY) && iter_done) begin
            result <= iter_res;
            flags  <= make_flags(iter_res, iter_carry, 1'b0);
        end
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's 16-bit combinational ALU.
- Adds:
  - generic WIDTH
  - registered result and a status-flag bundle
  - variable-amount shifts, executed iteratively
  - an optional iterative multiplier
- Sits between operand fetch and writeback in the datapath.
- Uses valid/ready on both sides so that multicycle ops stall upstream cleanly.

Parameters:
- WIDTH, 16, operand/result width. Must be a power of two and at least 4.
- SHW, $clog2(WIDTH), shift-amount width. Derived; do not override.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  block can accept a new op.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B. For shifts, b[SHW-1:0] is the shift amount.
- op  in  4  operation code (see Behaviour).
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- flag_c  out  1  carry / borrow / last bit shifted out / product high-half nonzero.
- flag_z  out  1  result == 0.
- flag_n  out  1  result[WIDTH-1].
- flag_v  out  1  signed overflow (ADD/SUB only, else 0).

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - out_valid=0, in_ready=1.
  - result=0 and all flags=0.
  - Reset mid-operation abandons the op; no result is produced.
- Op codes:
  - 0 ADD
  - 1 SUB (A-B)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOTA
  - 6 NOTB
  - 7 SHL by b[SHW-1:0]
  - 8 SHR (logical) by b[SHW-1:0]
  - 9 MUL (low WIDTH bits of A*B, unsigned)
  - Any other code: pass A.
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- Accept happens at an edge with in_valid && in_ready.
  - Single-cycle ops (0-6, default, and shifts with amount 0): result and flags are registered at the accept edge; go to DONE. Latency is 1 cycle.
  - Shift with amount n>0: go to BUSY with count=n; shift by 1 per cycle. Enter DONE after n BUSY cycles. Latency is n+1.
  - MUL: go to BUSY; shift-add over a 2*WIDTH accumulator, WIDTH iterations. Latency is WIDTH+1.
- In DONE:
  - result and flags hold stable until out_ready=1.
  - At that edge, return to IDLE.
  - Back-to-back throughput is at most 1 op per 2 cycles.
- in_valid while in BUSY or DONE is ignored; the source must hold it per the handshake.
- Flag rules:
  - ADD: C = bit WIDTH of the (WIDTH+1)-bit sum. V = operands have the same sign and the result sign differs.
  - SUB: C = borrow (A<B unsigned). V = operands have different signs and the result sign differs from A.
  - Logic ops and default: C=0, V=0.
  - Shifts: C = last bit shifted out (0 if amount is 0). V=0.
  - MUL: C = |high half of the product. V=0.
  - Z and N are always derived from the final result.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: op 9 performs the iterative multiply as specified.
- Undefined: no multiplier logic is synthesised. Op 9 decodes as the default (pass A, latency 1, C=V=0).

Decomposition:
- Package alu_seq_pkg holds:
  - op-code enum alu_op_e
  - state enum alu_state_e
  - flag struct alu_flags_t {c,z,n,v}
- One sub-module, alu_iter_unit, holds the BUSY-state shifter and multiplier datapath (count, accumulator, done pulse).
- The top level keeps the FSM, single-cycle ops and flag logic.

Test Plan (all cases use WIDTH=16):
1. Reset, then idle: hold rst 2 cycles -> out_valid=0, in_ready=1, result=0x0000, flags all 0.
2. ADD a=0xFFFF, b=0x0001 -> one cycle after accept: result=0x0000, C=1, Z=1, N=0, V=0.
3. SUB a=0x8000, b=0x0001 -> result=0x7FFF, C=0, V=1, N=0, Z=0; in_ready low until out_ready pulses.
4. SHL a=0x1001, b=4 -> out_valid exactly 5 cycles after accept, result=0x0010, C=1. SHR a=0x0003, b=0 -> latency 1, result=0x0003, C=0.
5. MUL with macro defined, a=0x0100, b=0x0100, out_ready held 0 for 3 extra cycles:
   - Response: out_valid 17 cycles after accept; result=0x0000, C=1, Z=1.
   - Outputs stay stable until out_ready=1.
   - The same stimulus with the macro undefined -> result=0x0100 after 1 cycle.
6. Reset mid-MUL: assert rst 5 cycles into BUSY -> next cycle state=IDLE, out_valid=0, in_ready=1. A new ADD 2+3 then gives 0x0005 with no stale result.
